// File: rtl/rst_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_pkg
//  Description : Shared types and helpers for the staged reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

   // Default width of the shared delay counter (holds 5e9 cycles).
   localparam int CNT_W_DEF   = 34;
   // Width of the stage index and fault_stage output (up to 8 stages).
   localparam int STAGE_IDX_W = 3;

   typedef enum logic [2:0] {
      S_WAIT_LOCK = 3'd0,
      S_POR       = 3'd1,
      S_STAGE     = 3'd2,
      S_ACK       = 3'd3,
      S_DONE      = 3'd4,
      S_FAULT     = 3'd5
   } seq_state_e;

   // Increment that sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_ctrl_lock_filt.sv
`default_nettype none
// ============================================================================
//  Module      : lock_filt
//  Description : 2-FF synchroniser for the asynchronous PLL lock followed by a
//                debounce that requires LOCK_FILT consecutive high samples.
//                lock_ok drops combinationally as soon as the synchronised
//                lock goes low.
//  Revision    : 1.0 - initial release
// ============================================================================
module lock_filt #(
   parameter int LOCK_FILT = 16
) (
   input  logic clk_100M,
   input  logic rst_n,
   input  logic locked,
   output logic lock_ok
);

   localparam int             FW       = $clog2(LOCK_FILT + 1);
   localparam logic [FW-1:0]  FILT_MAX = FW'(LOCK_FILT);

   logic [1:0]    sync_q, sync_d;
   logic [FW-1:0] filt_q, filt_d;

   // Shift the raw lock into the synchroniser and count consecutive highs.
   always_comb begin
      sync_d = {sync_q[0], locked};
      filt_d = filt_q;
      if (!sync_q[1]) begin
         filt_d = '0;
      end else if (filt_q != FILT_MAX) begin
         filt_d = filt_q + FW'(1);
      end
   end

   // Synchroniser and debounce counter registers.
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         filt_q <= '0;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
      end
   end

   assign lock_ok = sync_q[1] && (filt_q == FILT_MAX);

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_ctrl
//  Description : Staged reset sequencer. Waits for filtered PLL lock, holds a
//                power-on settle delay, then releases N_STAGE reset domains in
//                order, each gated by its ready acknowledge. Lock loss or a
//                software request restarts; ack timeout is flagged as a fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int               N_STAGE   = 4,
   parameter int               CNT_W     = CNT_W_DEF,
   parameter logic [CNT_W-1:0] POR_DLY   = 34'd5_000_000_000,
   parameter int               STAGE_DLY = 1000,
   parameter int               ACK_TMO   = 100000,
   parameter int               LOCK_FILT = 16
) (
   input  logic                   clk_100M,
   input  logic                   rst_n,
   input  logic                   locked,
   input  logic                   soft_rst_req,
   input  logic [N_STAGE-1:0]     stage_rdy,
   output logic [N_STAGE-1:0]     rst_stage_n,
   output logic                   seq_done,
   output logic                   seq_fault,
   output logic [STAGE_IDX_W-1:0] fault_stage,
   output logic [7:0]             relock_cnt
);

   localparam logic [CNT_W-1:0]       POR_TC   = POR_DLY - CNT_W'(1);
   localparam logic [CNT_W-1:0]       STAGE_TC = CNT_W'(STAGE_DLY - 1);
   localparam logic [CNT_W-1:0]       ACK_TC   = CNT_W'(ACK_TMO - 1);
   localparam logic [STAGE_IDX_W-1:0] LAST_IDX = STAGE_IDX_W'(N_STAGE - 1);

   logic                   lock_ok;
   logic                   lock_lost;
   logic [N_STAGE-1:0]     sel_mask;

   seq_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [STAGE_IDX_W-1:0] idx_q, idx_d;
   logic [N_STAGE-1:0]     rst_q, rst_d;
   logic                   done_q, done_d;
   logic                   fault_q, fault_d;
   logic [STAGE_IDX_W-1:0] fstage_q, fstage_d;
   logic [7:0]             relock_q, relock_d;

   lock_filt #(
      .LOCK_FILT (LOCK_FILT)
   ) u_lock_filt (
      .clk_100M (clk_100M),
      .rst_n    (rst_n),
      .locked   (locked),
      .lock_ok  (lock_ok)
   );

   // One-hot select of the stage currently being sequenced.
   assign sel_mask = N_STAGE'(1) << idx_q;
   // Every state past S_WAIT_LOCK was reached with lock held, so a low
   // lock_ok there is always a 1->0 transition.
   assign lock_lost = (state_q != S_WAIT_LOCK) && !lock_ok;

   // Next-state, counter and output-register logic; lock loss overrides all.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      rst_d    = rst_q;
      done_d   = done_q;
      fault_d  = fault_q;
      fstage_d = fstage_q;
      relock_d = relock_q;

      if (lock_lost) begin
         state_d  = S_WAIT_LOCK;
         cnt_d    = '0;
         idx_d    = '0;
         rst_d    = '0;
         done_d   = 1'b0;
         fault_d  = 1'b0;
         relock_d = sat_inc8(relock_q);
      end else begin
         case (state_q)
            S_WAIT_LOCK: begin
               rst_d = '0;
               if (lock_ok) begin
                  state_d = S_POR;
                  cnt_d   = '0;
               end
            end
            S_POR: begin
               if (cnt_q == POR_TC) begin
                  state_d = S_STAGE;
                  idx_d   = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_STAGE: begin
               if (cnt_q == STAGE_TC) begin
                  rst_d   = rst_q | sel_mask;
                  state_d = S_ACK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_ACK: begin
               if (|(stage_rdy & sel_mask)) begin
                  cnt_d = '0;
                  if (idx_q == LAST_IDX) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     idx_d   = idx_q + STAGE_IDX_W'(1);
                     state_d = S_STAGE;
                  end
               end else if (cnt_q == ACK_TC) begin
                  state_d  = S_FAULT;
                  cnt_d    = '0;
                  fault_d  = 1'b1;
                  fstage_d = idx_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_DONE, S_FAULT: begin
               // Software restart skips the power-on delay.
               if (soft_rst_req) begin
                  state_d = S_STAGE;
                  cnt_d   = '0;
                  idx_d   = '0;
                  rst_d   = '0;
                  done_d  = 1'b0;
                  fault_d = 1'b0;
               end
            end
            default: begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
               idx_d   = '0;
               rst_d   = '0;
               done_d  = 1'b0;
               fault_d = 1'b0;
            end
         endcase
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_WAIT_LOCK;
         cnt_q    <= '0;
         idx_q    <= '0;
         rst_q    <= '0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         fstage_q <= '0;
         relock_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         rst_q    <= rst_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
         fstage_q <= fstage_d;
         relock_q <= relock_d;
      end
   end

   assign rst_stage_n = rst_q;
   assign seq_done    = done_q;
   assign seq_fault   = fault_q;
   assign fault_stage = fstage_q;
   assign relock_cnt  = relock_q;

endmodule
`default_nettype wire
